// File: rtl/dino_pkg.sv
// Shared definitions for the obstacle datapath: game state codes, obstacle types,
// obstacle widths and the random thresholds used to pick the next obstacle.
package dino_pkg;

    typedef enum logic [1:0] {
        GsInit  = 2'd0,
        GsStart = 2'd1,
        GsEnd   = 2'd2,
        GsReset = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        ObLowBird       = 3'd0,
        ObHighBird      = 3'd1,
        ObSmallCactus   = 3'd2,
        ObCactusCluster = 3'd3,
        ObTallCactus    = 3'd4,
        ObNothing       = 3'd5
    } obstacle_e;

    localparam logic [9:0] WINDOW_WIDTH = 10'd640;

    localparam logic [9:0] WIDTH_TALL_CACTUS    = 10'd27;
    localparam logic [9:0] WIDTH_SMALL_CACTUS   = 10'd19;
    localparam logic [9:0] WIDTH_CACTUS_CLUSTER = 10'd77;
    localparam logic [9:0] WIDTH_BIRD           = 10'd44;

    // Inclusive upper bounds of each rand_val band; anything above LOW_BIRD is a high bird.
    localparam logic [6:0] RAND_NOTHING_MAX        = 7'd50;
    localparam logic [6:0] RAND_TALL_CACTUS_MAX    = 7'd60;
    localparam logic [6:0] RAND_SMALL_CACTUS_MAX   = 7'd70;
    localparam logic [6:0] RAND_CACTUS_CLUSTER_MAX = 7'd80;
    localparam logic [6:0] RAND_LOW_BIRD_MAX       = 7'd90;

    function automatic logic [2:0] lowest_one_hot(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

endpackage

// File: rtl/danger_type_map.sv
// Combinational map from a random value to an obstacle type and its width.
// Free of state so any spawner can share it.
module danger_type_map
    import dino_pkg::*;
(
    input  logic [6:0] i_rand_val,
    output logic [2:0] o_type,
    output logic [9:0] o_width
);

    always_comb begin
        o_type  = ObNothing;
        o_width = 10'd0;
        if (i_rand_val <= RAND_NOTHING_MAX) begin
            o_type  = ObNothing;
            o_width = 10'd0;
        end else if (i_rand_val <= RAND_TALL_CACTUS_MAX) begin
            o_type  = ObTallCactus;
            o_width = WIDTH_TALL_CACTUS;
        end else if (i_rand_val <= RAND_SMALL_CACTUS_MAX) begin
            o_type  = ObSmallCactus;
            o_width = WIDTH_SMALL_CACTUS;
        end else if (i_rand_val <= RAND_CACTUS_CLUSTER_MAX) begin
            o_type  = ObCactusCluster;
            o_width = WIDTH_CACTUS_CLUSTER;
        end else if (i_rand_val <= RAND_LOW_BIRD_MAX) begin
            o_type  = ObLowBird;
            o_width = WIDTH_BIRD;
        end else begin
            o_type  = ObHighBird;
            o_width = WIDTH_BIRD;
        end
    end

endmodule

// File: rtl/danger_spawn_sched.sv
// Obstacle spawn scheduler: paces motion via step_en, ramps the speed level, and
// offers one obstacle at a time to the lowest free slot over a valid/ack handshake.
module danger_spawn_sched
    import dino_pkg::*;
#(
    parameter int unsigned MIN_GAP     = 250,
    parameter int unsigned SKIP_GAP    = 100,
    parameter int unsigned LEVEL_TICKS = 4096,
    parameter int unsigned MAX_LEVEL   = 3
) (
    input  logic       game_clk,
    input  logic       rst,
    input  logic [1:0] i_game_state,
    input  logic [6:0] i_rand_val,
    input  logic [2:0] i_slot_en,
    input  logic       i_spawn_ack,
    output logic       o_spawn_valid,
    output logic [2:0] o_spawn_slot,
    output logic [2:0] o_spawn_type,
    output logic [9:0] o_spawn_pos,
    output logic [1:0] o_speed_level,
    output logic       o_step_en
);

    localparam logic [8:0]  MIN_GAP_W  = 9'(MIN_GAP);
    localparam logic [8:0]  SKIP_GAP_W = 9'(SKIP_GAP);
    localparam logic [12:0] LVL_LAST   = 13'(LEVEL_TICKS - 1);
    localparam logic [1:0]  LVL_MAX    = 2'(MAX_LEVEL);

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StPick,
        StBlocked,
        StOffer
    } sched_state_e;

    sched_state_e r_state;
    logic [8:0]   r_gap_cnt;
    logic [1:0]   r_step_cnt;
    logic [1:0]   r_step_lvl;
    logic [12:0]  r_lvl_cnt;
    logic [1:0]   r_speed_level;
    logic         r_step_en;
    logic         r_spawn_valid;
    logic [2:0]   r_spawn_slot;
    logic [2:0]   r_spawn_type;
    logic [9:0]   r_spawn_pos;

    game_state_e  w_gs;
    logic [2:0]   w_type;
    logic [9:0]   w_width;
    logic [2:0]   w_free;
    logic [2:0]   w_free_oh;
    logic         w_step_wrap;

    assign w_gs      = game_state_e'(i_game_state);
    assign w_free    = ~i_slot_en;
    assign w_free_oh = lowest_one_hot(w_free);
    // Period is latched at each wrap so a level change only takes effect on the next one.
    assign w_step_wrap = (r_step_cnt == (2'd3 - r_step_lvl));

    danger_type_map u_type_map (
        .i_rand_val (i_rand_val),
        .o_type     (w_type),
        .o_width    (w_width)
    );

    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_gap_cnt     <= 9'd0;
            r_step_cnt    <= 2'd0;
            r_step_lvl    <= 2'd0;
            r_lvl_cnt     <= 13'd0;
            r_speed_level <= 2'd0;
            r_step_en     <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= 3'b000;
            r_spawn_type  <= ObNothing;
            r_spawn_pos   <= 10'd0;
        end else if (w_gs == GsReset) begin
            r_state       <= StIdle;
            r_gap_cnt     <= 9'd0;
            r_step_cnt    <= 2'd0;
            r_step_lvl    <= 2'd0;
            r_lvl_cnt     <= 13'd0;
            r_speed_level <= 2'd0;
            r_step_en     <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= 3'b000;
            r_spawn_type  <= ObNothing;
            r_spawn_pos   <= 10'd0;
        end else if (w_gs == GsStart) begin
            if (w_step_wrap) begin
                r_step_cnt <= 2'd0;
                r_step_en  <= 1'b1;
                r_step_lvl <= r_speed_level;
            end else begin
                r_step_cnt <= r_step_cnt + 2'd1;
                r_step_en  <= 1'b0;
            end

            if (r_lvl_cnt == LVL_LAST) begin
                r_lvl_cnt <= 13'd0;
                if (r_speed_level != LVL_MAX) begin
                    r_speed_level <= r_speed_level + 2'd1;
                end
            end else begin
                r_lvl_cnt <= r_lvl_cnt + 13'd1;
            end

            case (r_state)
                StIdle: begin
                    r_state   <= StGap;
                    r_gap_cnt <= MIN_GAP_W;
                end
                StGap: begin
                    if (r_gap_cnt == 9'd0) begin
                        r_state <= StPick;
                    end else if (r_step_en) begin
                        r_gap_cnt <= r_gap_cnt - 9'd1;
                    end
                end
                StPick: begin
                    if (w_type == ObNothing) begin
                        r_gap_cnt <= SKIP_GAP_W;
                        r_state   <= StGap;
                    end else begin
                        r_spawn_type <= w_type;
                        r_spawn_pos  <= WINDOW_WIDTH + w_width;
                        if (w_free != 3'b000) begin
                            r_spawn_slot  <= w_free_oh;
                            r_spawn_valid <= 1'b1;
                            r_state       <= StOffer;
                        end else begin
                            r_state <= StBlocked;
                        end
                    end
                end
                StBlocked: begin
                    if (w_free != 3'b000) begin
                        r_spawn_slot  <= w_free_oh;
                        r_spawn_valid <= 1'b1;
                        r_state       <= StOffer;
                    end
                end
                StOffer: begin
                    if (i_spawn_ack) begin
                        r_spawn_valid <= 1'b0;
                        r_spawn_slot  <= 3'b000;
                        r_gap_cnt     <= MIN_GAP_W;
                        r_state       <= StGap;
                    end else if ((i_slot_en & r_spawn_slot) != 3'b000) begin
                        // Target slot was taken by someone else; keep the type and retry.
                        r_spawn_valid <= 1'b0;
                        r_spawn_slot  <= 3'b000;
                        r_state       <= StBlocked;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end else begin
            // INIT/END freeze everything except the acceptance of an already-visible offer.
            r_step_en <= 1'b0;
            if (r_state == StOffer && i_spawn_ack) begin
                r_spawn_valid <= 1'b0;
                r_spawn_slot  <= 3'b000;
                r_gap_cnt     <= MIN_GAP_W;
                r_state       <= StGap;
            end
        end
    end

    assign o_spawn_valid = r_spawn_valid;
    assign o_spawn_slot  = r_spawn_slot;
    assign o_spawn_type  = r_spawn_type;
    assign o_spawn_pos   = r_spawn_pos;
    assign o_speed_level = r_speed_level;
    assign o_step_en     = r_step_en;

endmodule

// File: tb/tb_danger_spawn_sched.sv
// Self-checking bench for danger_spawn_sched: directed scenarios plus random play,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_danger_spawn_sched;

    localparam int MIN_GAP     = 4;
    localparam int SKIP_GAP    = 2;
    localparam int LEVEL_TICKS = 8;

    localparam int M_IDLE    = 0;
    localparam int M_GAP     = 1;
    localparam int M_PICK    = 2;
    localparam int M_BLOCKED = 3;
    localparam int M_OFFER   = 4;

    logic       game_clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] game_state = 2'd0;
    logic [6:0] rand_val = 7'd0;
    logic [2:0] slot_en = 3'b000;
    logic       spawn_ack = 1'b0;
    logic       o_spawn_valid;
    logic [2:0] o_spawn_slot;
    logic [2:0] o_spawn_type;
    logic [9:0] o_spawn_pos;
    logic [1:0] o_speed_level;
    logic       o_step_en;
    logic [19:0] dut_outs;

    int n_tests = 0;
    int n_fail  = 0;

    danger_spawn_sched #(
        .MIN_GAP     (MIN_GAP),
        .SKIP_GAP    (SKIP_GAP),
        .LEVEL_TICKS (LEVEL_TICKS),
        .MAX_LEVEL   (3)
    ) dut (
        .game_clk      (game_clk),
        .rst           (rst),
        .i_game_state  (game_state),
        .i_rand_val    (rand_val),
        .i_slot_en     (slot_en),
        .i_spawn_ack   (spawn_ack),
        .o_spawn_valid (o_spawn_valid),
        .o_spawn_slot  (o_spawn_slot),
        .o_spawn_type  (o_spawn_type),
        .o_spawn_pos   (o_spawn_pos),
        .o_speed_level (o_speed_level),
        .o_step_en     (o_step_en)
    );

    assign dut_outs = {o_spawn_valid, o_spawn_slot, o_spawn_type, o_spawn_pos,
                       o_speed_level, o_step_en};

    always #5 game_clk = ~game_clk;

    // ---------------- behavioural reference model ----------------
    int         m_state, m_gap, m_level, m_ticks, m_cyc, m_last, m_period, m_skips;
    logic       m_valid, m_step;
    logic [2:0] m_slot, m_type;
    logic [9:0] m_pos;
    int         band_hi [5] = '{60, 70, 80, 90, 127};
    int         band_ty [5] = '{4, 2, 3, 0, 1};
    int         band_w  [5] = '{27, 19, 77, 44, 44};

    task automatic model_clear();
        m_state = M_IDLE; m_gap = 0; m_level = 0; m_ticks = 0;
        m_cyc = 0; m_last = 0; m_period = 4;
        m_valid = 1'b0; m_step = 1'b0; m_slot = 3'b000; m_type = 3'd5; m_pos = 10'd0;
    endtask

    task automatic model_accept();
        m_valid = 1'b0; m_slot = 3'b000; m_gap = MIN_GAP; m_state = M_GAP;
    endtask

    task automatic model_try_offer();
        bit found = 0;
        for (int i = 0; i < 3; i++) begin
            if (!found && !slot_en[i]) begin
                found = 1; m_slot = 3'b000; m_slot[i] = 1'b1;
            end
        end
        if (found) begin
            m_valid = 1'b1; m_state = M_OFFER;
        end else begin
            m_state = M_BLOCKED;
        end
    endtask

    task automatic model_update();
        bit done;
        if (game_state == 2'd3) begin
            model_clear();
        end else if (game_state == 2'd1) begin
            case (m_state)
                M_IDLE: begin m_state = M_GAP; m_gap = MIN_GAP; end
                M_GAP: begin
                    if (m_gap == 0) m_state = M_PICK;
                    else if (m_step) m_gap = m_gap - 1;
                end
                M_PICK: begin
                    if (rand_val <= 50) begin
                        m_gap = SKIP_GAP; m_state = M_GAP; m_skips++;
                    end else begin
                        done = 0;
                        for (int i = 0; i < 5; i++) begin
                            if (!done && int'(rand_val) <= band_hi[i]) begin
                                done = 1; m_type = 3'(band_ty[i]); m_pos = 10'(640 + band_w[i]);
                            end
                        end
                        model_try_offer();
                    end
                end
                M_BLOCKED: if (slot_en != 3'b111) model_try_offer();
                M_OFFER: begin
                    if (spawn_ack) model_accept();
                    else if ((slot_en & m_slot) != 3'b000) begin
                        m_valid = 1'b0; m_slot = 3'b000; m_state = M_BLOCKED;
                    end
                end
                default: ;
            endcase
            m_cyc++;
            if (m_cyc - m_last == m_period) begin
                m_step = 1'b1; m_last = m_cyc; m_period = 4 - m_level;
            end else begin
                m_step = 1'b0;
            end
            m_ticks++;
            if (m_ticks == LEVEL_TICKS) begin
                m_ticks = 0;
                if (m_level < 3) m_level++;
            end
        end else begin
            m_step = 1'b0;
            if (m_state == M_OFFER && spawn_ack) model_accept();
        end
    endtask

    function automatic logic [19:0] model_outs();
        return {m_valid, m_slot, m_type, m_pos, 2'(m_level), m_step};
    endfunction

    task automatic tick();
        @(posedge game_clk);
        model_update();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [19:0] reset_val;
        reset_val = {1'b0, 3'b000, 3'd5, 10'd0, 2'd0, 1'b0};
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge game_clk);
        #1;
        n_tests++;
        if (dut_outs !== reset_val) begin
            n_fail++;
            $display("FAIL reset_values got=%h want=%h", dut_outs, reset_val);
        end
        @(negedge game_clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_offer();
        int pulses = 0;
        bit seen = 0;
        game_state = 2'd1; rand_val = 7'd55; slot_en = 3'b000; spawn_ack = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL basic_model cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
            if (o_spawn_valid) seen = 1;
            else if (o_step_en) pulses++;
        end
        n_tests++;
        if (!seen || o_spawn_type !== 3'd4 || o_spawn_pos !== 10'd667 || o_spawn_slot !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_offer valid=%b type=%0d pos=%0d slot=%b want 1/4/667/001",
                     o_spawn_valid, o_spawn_type, o_spawn_pos, o_spawn_slot);
        end
        n_tests++;
        if (pulses != MIN_GAP) begin
            n_fail++;
            $display("FAIL basic_steps_before_offer got=%0d want=%0d", pulses, MIN_GAP);
        end
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;
        n_tests++;
        if (o_spawn_valid !== 1'b0 || o_spawn_slot !== 3'b000 || dut_outs !== model_outs()) begin
            n_fail++;
            $display("FAIL basic_ack_drop got=%h want=%h", dut_outs, model_outs());
        end
    endtask

    task automatic test_skip();
        int s0 = m_skips;
        bit seen = 0;
        rand_val = 7'd30;
        for (int i = 0; i < 200 && (m_skips - s0) < 2; i++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs() || o_spawn_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL skip_nothing cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
        end
        n_tests++;
        if ((m_skips - s0) < 2) begin
            n_fail++;
            $display("FAIL skip_timeout skips=%0d want=2", m_skips - s0);
        end
        rand_val = 7'd95;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL skip_model cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
            seen = o_spawn_valid;
        end
        n_tests++;
        if (!seen || o_spawn_type !== 3'd1 || o_spawn_pos !== 10'd684) begin
            n_fail++;
            $display("FAIL skip_then_bird valid=%b type=%0d pos=%0d want 1/1/684",
                     o_spawn_valid, o_spawn_type, o_spawn_pos);
        end
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
    endtask

    task automatic test_blocked();
        slot_en = 3'b111; rand_val = 7'd60;
        for (int i = 0; i < 200 && m_state != M_BLOCKED; i++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL blocked_model cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (o_spawn_valid !== 1'b0 || dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL blocked_hold cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
        end
        slot_en = 3'b101;
        tick();
        n_tests++;
        if (o_spawn_valid !== 1'b1 || o_spawn_slot !== 3'b010 || o_spawn_type !== 3'd4) begin
            n_fail++;
            $display("FAIL blocked_release valid=%b slot=%b type=%0d want 1/010/4",
                     o_spawn_valid, o_spawn_slot, o_spawn_type);
        end
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0; slot_en = 3'b000;
    endtask

    task automatic test_busy_drop();
        bit seen = 0;
        slot_en = 3'b110; rand_val = 7'd85;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL busy_model cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
            seen = o_spawn_valid;
        end
        n_tests++;
        if (!seen || o_spawn_slot !== 3'b001 || o_spawn_type !== 3'd0) begin
            n_fail++;
            $display("FAIL busy_offer slot=%b type=%0d want 001/0", o_spawn_slot, o_spawn_type);
        end
        slot_en = 3'b111;
        tick();
        n_tests++;
        if (o_spawn_valid !== 1'b0 || dut_outs !== model_outs()) begin
            n_fail++;
            $display("FAIL busy_drop got=%h want=%h", dut_outs, model_outs());
        end
        repeat (3) tick();
        slot_en = 3'b110;
        tick();
        n_tests++;
        if (o_spawn_valid !== 1'b1 || o_spawn_slot !== 3'b001 || o_spawn_type !== 3'd0
            || o_spawn_pos !== 10'd684) begin
            n_fail++;
            $display("FAIL busy_reoffer valid=%b slot=%b type=%0d pos=%0d want 1/001/0/684",
                     o_spawn_valid, o_spawn_slot, o_spawn_type, o_spawn_pos);
        end
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0; slot_en = 3'b000;
    endtask

    task automatic test_level();
        int first_step = -1;
        int want;
        game_state = 2'd3; tick();
        game_state = 2'd1; slot_en = 3'b111;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL level_model k=%0d got=%h want=%h", k, dut_outs, model_outs());
            end
            if (o_step_en && first_step < 0) first_step = k;
            if (k == 7 || k == 8 || k == 16 || k == 24 || k == 32 || k == 40) begin
                want = (k / LEVEL_TICKS > 3) ? 3 : k / LEVEL_TICKS;
                n_tests++;
                if (int'(o_speed_level) != want) begin
                    n_fail++;
                    $display("FAIL level_ramp k=%0d got=%0d want=%0d", k, o_speed_level, want);
                end
            end
            if (k >= 36) begin
                n_tests++;
                if (o_step_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL level_fast_step k=%0d got=%b want=1", k, o_step_en);
                end
            end
        end
        n_tests++;
        if (first_step != 4) begin
            n_fail++;
            $display("FAIL level_first_step got=%0d want=4", first_step);
        end
        slot_en = 3'b000;
    endtask

    task automatic test_end_freeze();
        logic [19:0] reset_val;
        bit seen = 0;
        reset_val = {1'b0, 3'b000, 3'd5, 10'd0, 2'd0, 1'b0};
        game_state = 2'd3; tick();
        game_state = 2'd1; rand_val = 7'd70;
        repeat (6) tick();
        game_state = 2'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (o_step_en !== 1'b0 || dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL end_freeze cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
        end
        game_state = 2'd1;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL end_resume cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
            seen = o_spawn_valid;
        end
        game_state = 2'd2;
        repeat (3) tick();
        n_tests++;
        if (o_spawn_valid !== 1'b1 || o_spawn_type !== 3'd2 || o_spawn_pos !== 10'd659) begin
            n_fail++;
            $display("FAIL end_offer_held valid=%b type=%0d pos=%0d want 1/2/659",
                     o_spawn_valid, o_spawn_type, o_spawn_pos);
        end
        spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
        n_tests++;
        if (o_spawn_valid !== 1'b0 || dut_outs !== model_outs()) begin
            n_fail++;
            $display("FAIL end_ack got=%h want=%h", dut_outs, model_outs());
        end
        game_state = 2'd3;
        tick();
        n_tests++;
        if (dut_outs !== reset_val) begin
            n_fail++;
            $display("FAIL game_reset got=%h want=%h", dut_outs, reset_val);
        end
    endtask

    task automatic test_rst_mid_offer();
        bit seen = 0;
        game_state = 2'd1; rand_val = 7'd100; slot_en = 3'b000;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = o_spawn_valid;
        end
        @(negedge game_clk);
        rst = 1'b1;
        model_clear();
        #1;
        n_tests++;
        if (!seen || o_spawn_valid !== 1'b0 || dut_outs !== model_outs()) begin
            n_fail++;
            $display("FAIL rst_mid_offer seen=%b got=%h want=%h", seen, dut_outs, model_outs());
        end
        @(negedge game_clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            game_state = (r < 85) ? 2'd1 : (r < 93) ? 2'd2 : (r < 98) ? 2'd0 : 2'd3;
            rand_val   = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) slot_en = 3'($urandom_range(0, 7));
            spawn_ack  = ($urandom_range(0, 3) == 0);
            tick();
            n_tests++;
            if (dut_outs !== model_outs()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, dut_outs, model_outs());
            end
        end
        spawn_ack = 1'b0;
    endtask

    initial begin
        m_skips = 0;
        model_clear();
        test_reset();
        test_basic_offer();
        test_skip();
        test_blocked();
        test_busy_drop();
        test_level();
        test_end_freeze();
        test_rst_mid_offer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
